// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: state encoding and default operand width shared by serial_subtractor
package serial_sub_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: combinational 1-bit full subtractor, d = a - b - bin with borrow-out bo
module full_subtractor_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bo
);
  assign o_d  = i_a ^ i_b ^ i_bin;
  assign o_bo = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock; define SERIAL_SUBTRACTOR_OVF_EN for the signed-overflow output ovf
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, w_res;
  logic [CNT_W-1:0] r_cnt;
  logic r_br, w_d, w_bo, w_accept, w_last;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic r_amsb, r_bmsb;
`endif
  full_subtractor_cell u_cell (
    .i_a  (r_a[0]),
    .i_b  (r_b[0]),
    .i_bin(r_br),
    .o_d  (w_d),
    .o_bo (w_bo)
  );
  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);
  // new difference bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
  assign w_res    = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
  // next state: accept from IDLE/DONE, leave RUN on the last bit
  always_comb begin
    w_next = w_accept ? S_RUN : w_last ? S_DONE : (r_state == S_RUN) ? S_RUN : S_IDLE;
    busy   = r_state == S_RUN;
    done   = r_state == S_DONE;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // operand load, one bit per RUN cycle, results registered on the final bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_cnt <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      r_amsb <= a[WIDTH-1];
      r_bmsb <= b[WIDTH-1];
`endif
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_bo;
      r_cnt <= r_cnt + CNT_W'(1);
      r_res <= w_res;
      if (w_last) begin
        diff <= w_res;
        bout <= w_bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf  <= (r_amsb ^ r_bmsb) & (w_d ^ r_amsb);
`endif
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: checks serial_subtractor (WIDTH=8 and WIDTH=1) against an arithmetic model and literal cases
module tb_serial_subtractor;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, bin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic busy, done, bout;
  logic [7:0] diff;
  logic s1 = 1'b0, bin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, diff1;
  logic busy1, done1, bout1;
  int checks = 0, errors = 0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic ovf, ovf1;
`endif

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .ovf(ovf1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: a job accepted at edge k completes on edge k+8; result is plain arithmetic
  logic m_act = 1'b0;
  longint m_e = 0, m_k = 0;
  logic [7:0] m_pd, e_diff = '0;
  logic m_pb, m_po, e_bout = 1'b0, e_ovf = 1'b0;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_act = 1'b0;
      e_diff = '0;
      e_bout = 1'b0;
      e_ovf = 1'b0;
    end else begin
      m_e++;
      if (m_act && m_e == m_k + 8) begin
        e_diff = m_pd;
        e_bout = m_pb;
        e_ovf = m_po;
      end
      if (start && !(m_act && m_e - 1 < m_k + 8)) begin
        m_k = m_e;
        m_act = 1'b1;
        m_pd = 8'(int'(a) - int'(b) - int'(bin));
        m_pb = int'(a) < int'(b) + int'(bin);
        m_po = (a[7] ^ b[7]) & (m_pd[7] ^ a[7]);
      end
    end
  end

  // compare the WIDTH=8 instance against the model every cycle outside reset
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("busy", busy, m_act && m_e < m_k + 8);
      chk("done", done, m_act && m_e == m_k + 8);
      chk("diff", diff, e_diff);
      chk("bout", bout, e_bout);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk("ovf", ovf, e_ovf);
`endif
    end
  end

  // pulse start with the given operands, wait for done, check literal results and latency
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        input logic [7:0] ed, input logic eb, input string nm);
    int n, bc;
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    n = 0;
    bc = int'(busy);
    while (!done && n < 20) begin
      @(posedge clk);
      #1 n++;
      bc += int'(busy);
    end
    chk({nm, " latency"}, n, 8);
    chk({nm, " busy cycles"}, bc, 8);
    chk({nm, " diff"}, diff, ed);
    chk({nm, " bout"}, bout, eb);
  endtask

  logic [7:0] tt_d, tt_b;
  initial begin
    int n, r;
    tt_d = 8'b1001_0110;
    tt_b = 8'b1000_1110;
    #12 rst = 1'b0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset diff", diff, 0);
    chk("reset bout", bout, 0);
    chk("reset w1 done", done1, 0);
    chk("reset w1 diff", diff1, 0);
    @(posedge clk);
    #1;
    run_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, "5A-23");
    run_op(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, "10-20");
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "00-00-1");
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "80-01");
    chk("80-01 ovf", ovf, 1);
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, "7F-FF");
    chk("7F-FF ovf", ovf, 1);
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "05-03");
    chk("05-03 ovf", ovf, 0);
`endif
    // back-to-back with start held, new operands in the DONE cycle
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!done && n < 30);
    chk("b2b first done", done, 1);
    chk("b2b first diff", diff, 8'h02);
    chk("b2b first bout", bout, 0);
    a = 8'h03; b = 8'h05;
    @(posedge clk);
    #1 n = 1;
    while (!done && n < 30) begin
      start = 1'($urandom_range(0, 1));
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      @(posedge clk);
      #1 n++;
    end
    start = 1'b0;
    chk("b2b spacing", n, 9);
    chk("b2b second diff", diff, 8'hFE);
    chk("b2b second bout", bout, 1);
    // reset four cycles into a run
    @(posedge clk);
    #1;
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort diff", diff, 0);
    chk("abort bout", bout, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-abort done", done, 0);
    run_op(8'hC8, 8'h64, 1'b1, 8'h63, 1'b0, "C8-64-1");
    // WIDTH=1 exhaustive truth table
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); bin1 = 1'(i);
      s1 = 1'b1;
      @(posedge clk);
      #1 s1 = 1'b0;
      chk("w1 busy", busy1, 1);
      chk("w1 early done", done1, 0);
      @(posedge clk);
      #1;
      r = int'(a1) - int'(b1) - int'(bin1);
      chk("w1 done", done1, 1);
      chk("w1 diff", diff1, tt_d[i]);
      chk("w1 bout", bout1, tt_b[i]);
      chk("w1 diff arith", diff1, r & 1);
      chk("w1 bout arith", bout1, r < 0);
    end
    // random traffic checked by the model every cycle
    for (int c = 0; c < 500; c++) begin
      start = ($urandom_range(0, 3) == 0);
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised bit-serial N-bit subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
- Reuses a single 1-bit full-subtractor cell plus a borrow register, in place of N combinational stages.
- Start/done handshake; sits beside the combinational subtractors as the area-optimised arithmetic option.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH)+1 (derived localparam), bit-counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; operands sampled on the edge where it is accepted
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse; diff/bout valid in that cycle
- diff  output  WIDTH  difference, held until the next completion
- bout  output  1  borrow-out of the MSB, held with diff

Behaviour:
- Reset (async, active-high):
  - state=IDLE, busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow register and counter cleared.
- FSM states: IDLE, RUN, DONE.
- start is accepted in IDLE or DONE only:
  - On the accepting edge, latch a and b into shift registers, load borrow reg with bin, clear counter, go to RUN.
  - start in RUN is ignored; operands are not re-sampled.
- RUN:
  - Each edge: cell computes d = a0^b0^br and bo = (~a0&b0) | (~(a0^b0)&br).
  - d shifts into the MSB of the result register; operand registers shift right; br <= bo; counter++.
  - After WIDTH RUN edges, go to DONE.
  - diff <= result register, bout <= final borrow, both on that same edge.
- DONE: done=1 for exactly one cycle, busy=0.
  - Next state is RUN if start=1, else IDLE (back-to-back operation, no bubble).
- Latency: start accepted at edge k; done high in the cycle following edge k+WIDTH.
  - busy=1 from edge k+1 through edge k+WIDTH.
  - Throughput: one result per WIDTH+1 cycles with start held high.
- Arithmetic: modulo 2^WIDTH. bout=1 iff a < b+bin (unsigned).
- WIDTH=1: one RUN cycle; output must equal the single full-subtractor truth table.
- Reset mid-RUN: immediate abort, no done pulse, diff/bout forced to 0.
- diff/bout change only on the completion edge or on reset; they hold between operations.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), registered with diff, meaning signed two's-complement overflow.
  - ovf = (a[MSB]^b[MSB]) & (diff[MSB]^a[MSB]), using the latched operand MSBs; valid for any bin.
  - Reset value 0.
- Not defined: port and logic absent; the interface is exactly as listed above.

Decomposition:
- Package serial_sub_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
- Sub-module full_subtractor_cell:
  - Purely combinational 1-bit cell (a, b, bin -> d, bo).
  - Instantiated once in the datapath; unit-testable against the 8-row truth table.
- Top holds the FSM, counter, shift registers and output registers.

Test Plan (WIDTH=8 unless stated):
- a=0x5A, b=0x23, bin=0, pulse start -> done exactly 8 edges later; diff=0x37, bout=0; busy high for 8 cycles.
- a=0x10, b=0x20, bin=0 -> diff=0xF0, bout=1; then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- start held high; a=0x05, b=0x03, then a=0x03, b=0x05 presented in the DONE cycle:
  - diff=0x02/bout=0, then diff=0xFE/bout=1.
  - Second done arrives 9 cycles after the first.
  - start pulses during RUN do not disturb the result.
- Assert rst 4 cycles into a RUN -> busy, diff and bout go to 0 immediately; no done pulse; next start completes normally.
- WIDTH=1, exhaustive over all 8 (a, b, bin) combinations -> diff/bout match the full-subtractor truth table, with done one edge after each start.
- SERIAL_SUBTRACTOR_OVF_EN defined:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1.
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1.
  - a=0x05, b=0x03 -> ovf=0.
